// File: rtl/game_state_keeper_pkg.sv
// Purpose: shared widths, field offsets and update-source codes for the game state keeper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package game_state_keeper_pkg;

  localparam int STATE_W    = 134;

  // game_state packing: {way[63:0], box[63:0], player[5:0]}
  localparam int WAY_MSB    = 133;
  localparam int WAY_LSB    = 70;
  localparam int BOX_MSB    = 69;
  localparam int BOX_LSB    = 6;
  localparam int PLAYER_MSB = 5;
  localparam int PLAYER_LSB = 0;

  typedef enum logic [1:0] {
    SEL_LOAD    = 2'b00,
    SEL_MOVE    = 2'b01,
    SEL_RSVD    = 2'b10,
    SEL_RETRACT = 2'b11
  } sel_e;

endpackage

// File: rtl/game_state_keeper_if.sv
// Purpose: controller <-> state keeper bundle (update request in, live state and counters out).
// Latency: n/a (wiring only).
// Backpressure: none; an update is accepted on every cycle en is high.
// Ports: en/sel/level_state/move_state driven by the controller side (master);
//        game_state/step_count/undo_count/can_retract driven by the keeper (slave).
interface game_state_keeper_if #(
  parameter int STEP_W  = 10,
  parameter int DEPTH_W = 3
);
  import game_state_keeper_pkg::*;

  logic               en;
  logic [1:0]         sel;
  logic [STATE_W-1:0] level_state;
  logic [STATE_W-1:0] move_state;
  logic [STATE_W-1:0] game_state;
  logic [STEP_W-1:0]  step_count;
  logic [DEPTH_W:0]   undo_count;
  logic               can_retract;

  modport master (
    output en, sel, level_state, move_state,
    input  game_state, step_count, undo_count, can_retract
  );

  modport slave (
    input  en, sel, level_state, move_state,
    output game_state, step_count, undo_count, can_retract
  );

endinterface

// File: rtl/game_state_keeper_history_ring.sv
// Purpose: DEPTH x W circular undo history; push overwrites the oldest entry when full.
// Latency: push/pop/clear take effect on the next edge; dout is combinational on the pointer.
// Backpressure: none; pop on an empty ring is ignored, push on a full ring overwrites.
// Ports: clk, reset (sync, active-high), push/pop/clear strobes, din (entry to save),
//        dout (most recently pushed entry), count (valid entries, 0..DEPTH).
module history_ring #(
  parameter int DEPTH   = 8,
  parameter int DEPTH_W = 3,
  parameter int W       = 134
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           push,
  input  logic           pop,
  input  logic           clear,
  input  logic [W-1:0]   din,
  output logic [W-1:0]   dout,
  output logic [DEPTH_W:0] count
);

  localparam logic [DEPTH_W-1:0] PTR_ONE  = 1;
  localparam logic [DEPTH_W:0]   CNT_ONE  = 1;
  localparam logic [DEPTH_W:0]   CNT_FULL = (DEPTH_W+1)'(DEPTH);

  logic [W-1:0]       mem [DEPTH];
  logic [DEPTH_W-1:0] wr_ptr;

  // Pointer wraps naturally because DEPTH is a power of two.
  assign dout = mem[wr_ptr - PTR_ONE];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + PTR_ONE;
      if (count != CNT_FULL) begin
        count <= count + CNT_ONE;
      end
    end else if (pop && (count != '0)) begin
      wr_ptr <= wr_ptr - PTR_ONE;
      count  <= count - CNT_ONE;
    end
  end

  // Storage carries no reset; entries beyond count are never read back.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/game_state_keeper.sv
// Purpose: live game state register, step counter and bounded undo for the current level.
// Latency: 1 cycle from an accepted update to game_state/step_count/undo_count.
// Backpressure: none; retract with an empty history and sel=10 are silently ignored.
// Ports: clk, reset (sync, active-high); bus (slave modport): en/sel/level_state/move_state in,
//        game_state/step_count/undo_count/can_retract out.
module game_state_keeper
  import game_state_keeper_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int DEPTH_W = 3,
  parameter int STEP_W  = 10
) (
  input  logic               clk,
  input  logic               reset,
  game_state_keeper_if.slave bus
);

  localparam logic [STEP_W-1:0] STEP_ONE = 1;
  localparam logic [STEP_W-1:0] STEP_MAX = '1;

  logic [STATE_W-1:0] state_q;
  logic [STEP_W-1:0]  step_q;
  logic [STATE_W-1:0] hist_top;
  logic [DEPTH_W:0]   hist_cnt;
  logic               do_load;
  logic               do_move;
  logic               do_retract;

  always_comb begin
    do_load    = 1'b0;
    do_move    = 1'b0;
    do_retract = 1'b0;
    if (bus.en) begin
      case (bus.sel)
        SEL_LOAD:    do_load    = 1'b1;
        SEL_MOVE:    do_move    = 1'b1;
        // An empty history makes retract a full no-op, including the step counter.
        SEL_RETRACT: do_retract = (hist_cnt != '0);
        default:     ;
      endcase
    end
  end

  history_ring #(
    .DEPTH   (DEPTH),
    .DEPTH_W (DEPTH_W),
    .W       (STATE_W)
  ) u_history (
    .clk   (clk),
    .reset (reset),
    .push  (do_move),
    .pop   (do_retract),
    .clear (do_load),
    .din   (state_q),
    .dout  (hist_top),
    .count (hist_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= '0;
      step_q  <= '0;
    end else if (do_load) begin
      state_q <= bus.level_state;
      step_q  <= '0;
    end else if (do_move) begin
      state_q <= bus.move_state;
      if (step_q != STEP_MAX) begin
        step_q <= step_q + STEP_ONE;
      end
    end else if (do_retract) begin
      state_q <= hist_top;
      if (step_q != '0) begin
        step_q <= step_q - STEP_ONE;
      end
    end
  end

  assign bus.game_state  = state_q;
  assign bus.step_count  = step_q;
  assign bus.undo_count  = hist_cnt;
  assign bus.can_retract = (hist_cnt != '0);

endmodule

// File: tb/tb_game_state_keeper.sv
// Purpose: directed bench for game_state_keeper with a queue-based reference model.
// Latency: checks every falling edge, one cycle after each driven update.
// Backpressure: n/a.
module tb_game_state_keeper;
  import game_state_keeper_pkg::*;

  localparam int DEPTH   = 8;
  localparam int DEPTH_W = 3;
  localparam int STEP_W  = 10;
  localparam int STEP_SAT = (1 << STEP_W) - 1;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_bad;
  bit   chk_en;

  game_state_keeper_if #(.STEP_W(STEP_W), .DEPTH_W(DEPTH_W)) bus ();

  game_state_keeper #(.DEPTH(DEPTH), .DEPTH_W(DEPTH_W), .STEP_W(STEP_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [STATE_W-1:0] mk(input int k);
    logic [63:0] w;
    logic [63:0] b;
    w = 64'hA5A5_0000_0000_0000 | 64'(k);
    b = 64'hFFFF_FFFF_FFFF_FFFF ^ (64'(k) << 8);
    return {w, b, 6'(k)};
  endfunction

  task automatic chk(input string nm, input logic [STATE_W-1:0] act, input logic [STATE_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the history is simply a list of earlier states, trimmed to DEPTH.
  logic [STATE_W-1:0] m_state;
  logic [STATE_W-1:0] m_hist[$];
  int                 m_step;

  always @(posedge clk) begin
    if (reset) begin
      m_state = '0;
      m_hist.delete();
      m_step = 0;
    end else if (bus.en) begin
      case (bus.sel)
        2'b00: begin
          m_state = bus.level_state;
          m_hist.delete();
          m_step = 0;
        end
        2'b01: begin
          m_hist.push_back(m_state);
          if (m_hist.size() > DEPTH) void'(m_hist.pop_front());
          m_state = bus.move_state;
          if (m_step < STEP_SAT) m_step++;
        end
        2'b11: begin
          if (m_hist.size() > 0) begin
            m_state = m_hist.pop_back();
            if (m_step > 0) m_step--;
          end
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_state", bus.game_state, m_state);
      chk("model_step", STATE_W'(bus.step_count), STATE_W'(m_step));
      chk("model_undo", STATE_W'(bus.undo_count), STATE_W'(m_hist.size()));
      chk("model_can", STATE_W'(bus.can_retract), STATE_W'(m_hist.size() != 0));
    end
  end

  task automatic op(input logic e, input logic [1:0] s, input logic [STATE_W-1:0] lv,
                    input logic [STATE_W-1:0] mv);
    bus.en          = e;
    bus.sel         = s;
    bus.level_state = lv;
    bus.move_state  = mv;
    @(negedge clk);
  endtask

  task automatic pin(input string nm, input logic [STATE_W-1:0] st, input int step, input int undo);
    chk({nm, "_state"}, bus.game_state, st);
    chk({nm, "_step"}, STATE_W'(bus.step_count), STATE_W'(step));
    chk({nm, "_undo"}, STATE_W'(bus.undo_count), STATE_W'(undo));
    chk({nm, "_can"}, STATE_W'(bus.can_retract), STATE_W'(undo != 0));
  endtask

  logic [STATE_W-1:0] l1;
  logic [STATE_W-1:0] junk;

  initial begin
    n_vec  = 0;
    n_bad  = 0;
    chk_en = 1'b0;
    l1     = mk(200);
    junk   = mk(999);
    reset  = 1'b1;
    bus.en = 1'b0;
    bus.sel = 2'b00;
    bus.level_state = '0;
    bus.move_state  = '0;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    pin("reset", '0, 0, 0);
    reset = 1'b0;

    // Load, then retract on empty history.
    op(1'b1, 2'b00, l1, junk);
    pin("load", l1, 0, 0);
    op(1'b1, 2'b11, junk, junk);
    pin("retract_empty", l1, 0, 0);

    // Three moves and three retracts.
    for (int i = 1; i <= 3; i++) op(1'b1, 2'b01, junk, mk(i));
    pin("move3", mk(3), 3, 3);
    op(1'b1, 2'b11, junk, junk);
    pin("ret1", mk(2), 2, 2);
    op(1'b1, 2'b11, junk, junk);
    pin("ret2", mk(1), 1, 1);
    op(1'b1, 2'b11, junk, junk);
    pin("ret3", l1, 0, 0);

    // Holds: reserved code, and en low with every sel.
    op(1'b1, 2'b01, junk, mk(7));
    op(1'b1, 2'b10, mk(300), mk(301));
    pin("hold_rsvd", mk(7), 1, 1);
    for (int s = 0; s < 4; s++) op(1'b0, 2'(s), mk(400 + s), mk(500 + s));
    pin("hold_en0", mk(7), 1, 1);

    // Wrap: 10 moves, 9 retracts.
    op(1'b1, 2'b00, l1, junk);
    for (int i = 1; i <= 10; i++) op(1'b1, 2'b01, junk, mk(i));
    pin("move10", mk(10), 10, DEPTH);
    for (int i = 1; i <= 8; i++) op(1'b1, 2'b11, junk, junk);
    pin("ret8", mk(2), 2, 0);
    op(1'b1, 2'b11, junk, junk);
    pin("ret9", mk(2), 2, 0);

    // Back-to-back move then retract restores exactly.
    op(1'b1, 2'b01, junk, mk(50));
    op(1'b1, 2'b11, junk, junk);
    pin("move_ret", mk(2), 2, 0);

    // Reset mid-level while a move is requested.
    op(1'b1, 2'b00, l1, junk);
    for (int i = 1; i <= 3; i++) op(1'b1, 2'b01, junk, mk(60 + i));
    bus.en = 1'b1;
    bus.sel = 2'b01;
    bus.move_state = mk(64);
    @(negedge clk);
    reset = 1'b1;
    bus.move_state = mk(65);
    @(negedge clk);
    pin("reset_mid", '0, 0, 0);
    reset = 1'b0;
    op(1'b1, 2'b00, l1, junk);
    pin("reload", l1, 0, 0);

    // Step counter saturation.
    for (int i = 1; i <= STEP_SAT + 7; i++) op(1'b1, 2'b01, junk, mk(1000 + i));
    pin("sat", mk(1000 + STEP_SAT + 7), STEP_SAT, DEPTH);
    op(1'b1, 2'b11, junk, junk);
    pin("sat_ret", mk(1000 + STEP_SAT + 6), STEP_SAT - 1, DEPTH - 1);

    op(1'b0, 2'b00, junk, junk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/game_state_keeper.md
# game_state_keeper

Holds the live 134-bit game state (way map, box map, player cursor) for the current level, plus a bounded undo history. It sits directly downstream of the game controller and consumes its `game_state_en` and `sel` outputs. It returns `game_state` to the controller, the renderer and the move logic. Each cycle it loads a fresh level, commits a move, or retracts one step, and keeps a step counter for display.

## Interface
Parameters:
- `DEPTH`, 8: undo history entries; must be a power of two.
- `DEPTH_W`, 3: log2(`DEPTH`).
- `STEP_W`, 10: step counter width.

Ports:
- `clk`  in  1  single system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `en`  in  1  update enable; wired to controller `game_state_en`.
- `sel`  in  2  update source, from controller: 00 = level load, 01 = move commit, 11 = retract, 10 = reserved.
- `level_state`  in  134  initial state from the stage ROM for the current stage.
- `move_state`  in  134  next state computed by the move logic.
- `game_state`  out  134  current state, packed as {way[63:0], box[63:0], player[5:0]}.
- `step_count`  out  `STEP_W`  moves made in this level, net of retracts.
- `undo_count`  out  `DEPTH_W`+1  number of valid history entries, 0..`DEPTH`.
- `can_retract`  out  1  high when `undo_count` != 0.

## Operation
- Reset: `game_state`=0, `step_count`=0, `undo_count`=0, write pointer=0. History contents are don't-care.
- `en`=0: all state holds.
- `en`=1, `sel`=00 (load):
  - `game_state` <= `level_state`.
  - History is cleared: `undo_count`=0, pointer=0.
  - `step_count`=0.
- `en`=1, `sel`=01 (move):
  - Current `game_state` is pushed into history at the write pointer, and the pointer increments modulo `DEPTH`.
  - `game_state` <= `move_state`.
  - `undo_count` increments, saturating at `DEPTH`. When the history is full, the oldest entry is overwritten (circular buffer).
  - `step_count` increments, saturating at all-ones.
- `en`=1, `sel`=11 (retract):
  - If `undo_count`>0: pointer decrements modulo `DEPTH`, `game_state` <= history[pointer-1], `undo_count` decrements, and `step_count` decrements with a floor of 0.
  - If `undo_count`=0: no change to any register.
- `en`=1, `sel`=10: treated as hold; no register changes.
- Priority: `reset` overrides `en`. Only one operation can occur per cycle, because `sel` is a single code.
- Retracts are capped at `DEPTH` consecutive steps. After a wrap, steps older than `DEPTH` are unrecoverable, but `step_count` still reflects the true net step count.
- `step_count` saturation: once it is all-ones, a move leaves it at all-ones, and a retract decrements it by 1.

## Timing
- All outputs are registered. An update sampled at edge N is visible on `game_state` after edge N; latency is 1 cycle.
- The history read on retract is from the register array and is combinational on the pointer, so a retract completes in the same single edge.
- Back-to-back operations on consecutive cycles must work. For example, move then retract on the next cycle restores the pre-move state exactly.
- The controller's reset sequence asserts `en` with `sel`=00 in the cycles after `reset` falls, so the level is loaded without any extra handshake.
- `reset` asserted mid-level: on the next edge, all outputs return to their reset values regardless of `en`/`sel`.
- `can_retract` is derived combinationally from the registered `undo_count`; it has no extra latency.

## Structure
- Shared package holds:
  - field offsets: WAY_MSB=133, WAY_LSB=70, BOX_MSB=69, BOX_LSB=6, PLAYER_MSB=5;
  - `STATE_W`=134;
  - `sel` codes SEL_LOAD=2'b00, SEL_MOVE=2'b01, SEL_RETRACT=2'b11.
- Sub-module `history_ring`, a `DEPTH` x `STATE_W` circular register file:
  - inputs: push, pop, clear, `din`;
  - outputs: `dout` (top entry), count;
  - owns the pointer, count saturation and wrap logic.
- The top level holds the `game_state` register, `step_count` and `sel` decoding.

## Test plan
- Reset, then `en`=1, `sel`=00 with `level_state`=L1 → `game_state`=L1, `step_count`=0, `undo_count`=0, `can_retract`=0.
- From L1: three moves to M1, M2, M3, then three retracts → `game_state` steps back M2, M1, L1. `step_count` goes 3, 2, 1, 0 and `undo_count` goes 3, 2, 1, 0.
- From L1: 10 moves (M1..M10) with `DEPTH`=8, then 9 retracts → after 8 retracts `game_state`=M2 and `step_count`=2. The 9th retract is a no-op: `game_state` stays M2, `step_count`=2, `can_retract`=0.
- Retract with empty history right after a load → `game_state`, `step_count` and `undo_count` all unchanged.
- `sel`=10 with `en`=1, and separately any `sel` with `en`=0 → no register changes.
- After 4 moves, assert `reset` while `en`=1 and `sel`=01 → next cycle `game_state`=0, `step_count`=0, `undo_count`=0; a subsequent load restores L1.
